// File: rtl/sev_seg_pkg.sv
// Shared constants and state type for the
// seven-segment scan controller.
package sev_seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam int SEG_DP_BIT = 0;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_DRIVE,
    ST_GAP
  } state_e;

endpackage

// File: rtl/sev_seg_dec.sv
// Hex nibble to common-anode segment pattern.
// Output is {a,b,c,d,e,f,g,dp}, active-low, dp off.
module sev_seg_dec (
  input  logic [3:0] enc_input,
  output logic [7:0] dec_output
);

  always_comb begin
    dec_output = 8'hFF;
    unique case (enc_input)
      4'h0: dec_output = 8'h03;
      4'h1: dec_output = 8'h9F;
      4'h2: dec_output = 8'h25;
      4'h3: dec_output = 8'h0D;
      4'h4: dec_output = 8'h99;
      4'h5: dec_output = 8'h49;
      4'h6: dec_output = 8'h41;
      4'h7: dec_output = 8'h1F;
      4'h8: dec_output = 8'h01;
      4'h9: dec_output = 8'h09;
      4'hA: dec_output = 8'h11;
      4'hB: dec_output = 8'hC1;
      4'hC: dec_output = 8'h63;
      4'hD: dec_output = 8'h85;
      4'hE: dec_output = 8'h61;
      4'hF: dec_output = 8'h71;
    endcase
  end

endmodule

// File: rtl/sev_seg_scan.sv
// Multiplexed common-anode display scanner with
// blanking gap, leading-zero blank and frame commit.
module sev_seg_scan
  import sev_seg_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int ON_CYCLES  = 50000,
  parameter int GAP_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  blank_lz,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam int CNT_MAX =
    (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] ON_LAST =
    CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(DIGITS - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [4*DIGITS-1:0] shd_val_q, shd_val_d;
  logic [DIGITS-1:0]   shd_dp_q, shd_dp_d;
  logic                pend_q, pend_d;
  logic [4*DIGITS-1:0] act_val_q, act_val_d;
  logic [DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                tick_q, tick_d;

  logic                slot_end;
  logic                start;
  logic                wrap;
  logic                commit;
  logic [3:0]          nibble;
  logic [7:0]          dec_out;
  logic [DIGITS-1:0]   zero_hi;
  logic                lz_blank;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    slot_end = 1'b0;
    start    = 1'b0;
    wrap     = 1'b0;
    unique case (state_q)
      ST_OFF: begin
        if (enable) begin
          state_d = ST_DRIVE;
          idx_d   = '0;
          cnt_d   = '0;
          start   = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (cnt_q != ON_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (GAP_CYCLES != 0) state_d = ST_GAP;
          else slot_end = 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q != GAP_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d    = '0;
          state_d  = ST_DRIVE;
          slot_end = 1'b1;
        end
      end
      default: state_d = ST_OFF;
    endcase
    if (slot_end) begin
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
        wrap  = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
    if (!enable) begin
      state_d = ST_OFF;
      idx_d   = '0;
      cnt_d   = '0;
      start   = 1'b0;
      wrap    = 1'b0;
    end
  end

  assign commit = start | wrap;

  // A load on the commit cycle bypasses the shadow.
  always_comb begin
    shd_val_d = shd_val_q;
    shd_dp_d  = shd_dp_q;
    pend_d    = pend_q;
    act_val_d = act_val_q;
    act_dp_d  = act_dp_q;
    if (commit) begin
      if (load) begin
        act_val_d = value;
        act_dp_d  = dp_mask;
      end else if (pend_q) begin
        act_val_d = shd_val_q;
        act_dp_d  = shd_dp_q;
      end
      pend_d = 1'b0;
    end else if (load) begin
      shd_val_d = value;
      shd_dp_d  = dp_mask;
      pend_d    = 1'b1;
    end
  end

  assign nibble = act_val_d[{idx_d, 2'b00} +: 4];

  sev_seg_dec u_dec (
    .enc_input  (nibble),
    .dec_output (dec_out)
  );

  always_comb begin
    logic z;
    z       = 1'b1;
    zero_hi = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      z          = z & (act_val_d[4*i +: 4] == 4'h0);
      zero_hi[i] = z;
    end
  end

  assign lz_blank = blank_lz && (idx_d != '0)
                    && zero_hi[idx_d];

  // Outputs are registered from next-state values.
  always_comb begin
    an_d   = '1;
    seg_d  = SEG_BLANK;
    tick_d = wrap;
    if (state_d == ST_DRIVE) begin
      an_d[idx_d] = 1'b0;
      seg_d = lz_blank ? SEG_BLANK : dec_out;
      if (act_dp_d[idx_d]) seg_d[SEG_DP_BIT] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_OFF;
      idx_q     <= '0;
      cnt_q     <= '0;
      shd_val_q <= '0;
      shd_dp_q  <= '0;
      pend_q    <= 1'b0;
      act_val_q <= '0;
      act_dp_q  <= '0;
      seg_q     <= SEG_BLANK;
      an_q      <= '1;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      shd_val_q <= shd_val_d;
      shd_dp_q  <= shd_dp_d;
      pend_q    <= pend_d;
      act_val_q <= act_val_d;
      act_dp_q  <= act_dp_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      tick_q    <= tick_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_sev_seg_scan.sv
// Self-checking bench for sev_seg_scan against a
// frame-position reference model.
module tb_sev_seg_scan;

  localparam int D     = 4;
  localparam int ON    = 4;
  localparam int GAP   = 1;
  localparam int SLOT  = ON + GAP;
  localparam int FRAME = D * SLOT;

  localparam logic [7:0] FONT [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_mask = '0;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;

  int checks = 0;
  int failures = 0;

  sev_seg_scan #(
    .DIGITS     (D),
    .ON_CYCLES  (ON),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load       (load),
    .value      (value),
    .dp_mask    (dp_mask),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Model: position in frame since scanning started.
  bit          m_run, m_tick, m_pend, m_blz;
  int          m_t;
  logic [15:0] m_sv, m_av;
  logic [3:0]  m_sd, m_ad;

  task automatic model_reset();
    m_run = 0; m_tick = 0; m_pend = 0; m_blz = 0;
    m_t = 0; m_sv = '0; m_av = '0; m_sd = '0; m_ad = '0;
  endtask

  task automatic model_commit(input logic ld,
      input logic [15:0] v, input logic [3:0] dm);
    if (ld) begin
      m_av = v; m_ad = dm;
    end else if (m_pend) begin
      m_av = m_sv; m_ad = m_sd;
    end
    m_pend = 0;
  endtask

  task automatic cyc();
    logic en, ld, blz;
    logic [15:0] v;
    logic [3:0] dm;
    en = enable; ld = load; blz = blank_lz;
    v = value; dm = dp_mask;
    @(posedge clk);
    m_tick = 0;
    m_blz = blz;
    if (!en) begin
      m_run = 0; m_t = 0;
      if (ld) begin m_sv = v; m_sd = dm; m_pend = 1; end
    end else if (!m_run) begin
      m_run = 1; m_t = 0;
      model_commit(ld, v, dm);
    end else begin
      m_t++;
      if (m_t == FRAME) begin
        m_t = 0; m_tick = 1;
        model_commit(ld, v, dm);
      end else if (ld) begin
        m_sv = v; m_sd = dm; m_pend = 1;
      end
    end
    #1;
  endtask

  function automatic logic [3:0] exp_an();
    int d;
    if (!m_run || (m_t % SLOT) >= ON) return 4'hF;
    d = m_t / SLOT;
    return 4'(~(4'b0001 << d));
  endfunction

  function automatic logic [7:0] exp_seg();
    int d;
    logic [3:0] n;
    logic [7:0] s;
    if (!m_run || (m_t % SLOT) >= ON) return 8'hFF;
    d = m_t / SLOT;
    n = 4'(m_av >> (4 * d));
    if (m_blz && d != 0 && (m_av >> (4 * d)) == 16'h0)
      s = 8'hFF;
    else
      s = FONT[n];
    if (m_ad[d]) s[0] = 1'b0;
    return s;
  endfunction

  task automatic start(input logic [15:0] v,
      input logic [3:0] dm, input logic blz);
    enable = 0; load = 1; value = v;
    dp_mask = dm; blank_lz = blz;
    cyc();
    load = 0; enable = 1;
    cyc();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks += 3;
    if (seg !== 8'hFF) begin failures++;
      $display("FAIL rst_seg got=%h want=ff", seg); end
    if (an !== 4'hF) begin failures++;
      $display("FAIL rst_an got=%b want=1111", an); end
    if (frame_tick !== 1'b0) begin failures++;
      $display("FAIL rst_tick got=%b want=0", frame_tick); end
    rst_n = 1;
    start(16'h1234, 4'h0, 1'b0);
    repeat (7) cyc();
    #2 rst_n = 0;
    #1;
    checks += 2;
    if (seg !== 8'hFF) begin failures++;
      $display("FAIL rst_mid_seg got=%h want=ff", seg); end
    if (an !== 4'hF) begin failures++;
      $display("FAIL rst_mid_an got=%b want=1111", an); end
    #2 rst_n = 1;
    enable = 0;
    model_reset();
    repeat (3) begin
      cyc();
      checks += 2;
      if (an !== 4'hF) begin failures++;
        $display("FAIL rst_hold_an got=%b want=1111", an); end
      if (seg !== 8'hFF) begin failures++;
        $display("FAIL rst_hold_seg got=%h want=ff", seg); end
    end
    enable = 1;
    cyc();
    checks += 2;
    if (an !== 4'hE) begin failures++;
      $display("FAIL rst_first_an got=%b want=1110", an); end
    if (seg !== 8'h03) begin failures++;
      $display("FAIL rst_first_seg got=%h want=03", seg); end
  endtask

  task automatic test_basic_scan();
    logic [7:0] ws [4];
    int ticks;
    ws = '{8'h71, 8'h11, 8'h25, 8'h9F};
    ticks = 0;
    start(16'h12AF, 4'h0, 1'b0);
    for (int i = 0; i <= 2 * FRAME; i++) begin
      if (i > 0) cyc();
      ticks += int'(frame_tick);
      checks += 3;
      if (an !== exp_an()) begin failures++;
        $display("FAIL basic_an t=%0d got=%b want=%b",
                 m_t, an, exp_an()); end
      if (seg !== exp_seg()) begin failures++;
        $display("FAIL basic_seg t=%0d got=%h want=%h",
                 m_t, seg, exp_seg()); end
      if (frame_tick !== m_tick) begin failures++;
        $display("FAIL basic_tick t=%0d got=%b want=%b",
                 m_t, frame_tick, m_tick); end
      if (m_t % SLOT == 0) begin
        checks++;
        if (seg !== ws[m_t / SLOT]) begin failures++;
          $display("FAIL basic_font t=%0d got=%h want=%h",
                   m_t, seg, ws[m_t / SLOT]); end
      end
    end
    checks++;
    if (ticks != 2) begin failures++;
      $display("FAIL basic_ticks got=%0d want=2", ticks); end
  endtask

  task automatic test_lz();
    logic [7:0] ws [4];
    logic [15:0] vals [2];
    vals = '{16'h0050, 16'h0000};
    for (int k = 0; k < 2; k++) begin
      if (k == 0) ws = '{8'h03, 8'h49, 8'hFF, 8'hFF};
      else        ws = '{8'h03, 8'hFF, 8'hFF, 8'hFF};
      start(vals[k], 4'h0, 1'b1);
      for (int i = 0; i < FRAME; i++) begin
        if (i > 0) cyc();
        checks += 2;
        if (an !== exp_an()) begin failures++;
          $display("FAIL lz_an t=%0d got=%b want=%b",
                   m_t, an, exp_an()); end
        if (seg !== exp_seg()) begin failures++;
          $display("FAIL lz_seg t=%0d got=%h want=%h",
                   m_t, seg, exp_seg()); end
        if (m_t % SLOT == 0) begin
          checks++;
          if (seg !== ws[m_t / SLOT]) begin failures++;
            $display("FAIL lz_fixed v=%h t=%0d got=%h want=%h",
                     vals[k], m_t, seg, ws[m_t / SLOT]); end
        end
      end
    end
  endtask

  task automatic test_dp();
    logic [7:0] ws [4];
    ws = '{8'h03, 8'h03, 8'h0C, 8'hFF};
    start(16'h0300, 4'b0100, 1'b1);
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) cyc();
      checks++;
      if (seg !== exp_seg()) begin failures++;
        $display("FAIL dp_seg t=%0d got=%h want=%h",
                 m_t, seg, exp_seg()); end
      if (m_t % SLOT == 0) begin
        checks++;
        if (seg !== ws[m_t / SLOT]) begin failures++;
          $display("FAIL dp_fixed t=%0d got=%h want=%h",
                   m_t, seg, ws[m_t / SLOT]); end
      end
    end
  endtask

  task automatic test_load_timing();
    int k;
    start(16'h2222, 4'h0, 1'b0);
    repeat (5) cyc();
    load = 1; value = 16'h1111; dp_mask = 4'h0;
    cyc();
    load = 0;
    k = 0;
    while (m_t != 0 && k < 40) begin
      cyc();
      k++;
      checks++;
      if (seg !== exp_seg()) begin failures++;
        $display("FAIL ld_seg t=%0d got=%h want=%h",
                 m_t, seg, exp_seg()); end
      if (m_t == 10 || m_t == 15) begin
        checks++;
        if (seg !== 8'h25) begin failures++;
          $display("FAIL ld_old t=%0d got=%h want=25",
                   m_t, seg); end
      end
    end
    checks += 2;
    if (seg !== 8'h9F) begin failures++;
      $display("FAIL ld_new got=%h want=9f", seg); end
    if (frame_tick !== 1'b1) begin failures++;
      $display("FAIL ld_tick got=%b want=1", frame_tick); end
    k = 0;
    while (m_t != FRAME - 1 && k < 40) begin
      cyc();
      k++;
    end
    load = 1; value = 16'h3333;
    cyc();
    load = 0;
    checks += 3;
    if (seg !== 8'h0D) begin failures++;
      $display("FAIL ld_bypass_seg got=%h want=0d", seg); end
    if (an !== 4'hE) begin failures++;
      $display("FAIL ld_bypass_an got=%b want=1110", an); end
    if (frame_tick !== 1'b1) begin failures++;
      $display("FAIL ld_bypass_tick got=%b want=1",
               frame_tick); end
  endtask

  task automatic test_enable_drop();
    int ticks;
    start(16'h4321, 4'h0, 1'b0);
    repeat (11) cyc();
    enable = 0; load = 1; value = 16'h8888;
    cyc();
    load = 0;
    checks += 3;
    if (an !== 4'hF) begin failures++;
      $display("FAIL drop_an got=%b want=1111", an); end
    if (seg !== 8'hFF) begin failures++;
      $display("FAIL drop_seg got=%h want=ff", seg); end
    if (frame_tick !== 1'b0) begin failures++;
      $display("FAIL drop_tick got=%b want=0", frame_tick); end
    enable = 1;
    cyc();
    checks += 3;
    if (an !== 4'hE) begin failures++;
      $display("FAIL reen_an got=%b want=1110", an); end
    if (seg !== 8'h01) begin failures++;
      $display("FAIL reen_seg got=%h want=01", seg); end
    if (frame_tick !== 1'b0) begin failures++;
      $display("FAIL reen_tick got=%b want=0", frame_tick); end
    ticks = 0;
    repeat (FRAME - 1) begin
      cyc();
      ticks += int'(frame_tick);
      checks++;
      if (an !== exp_an()) begin failures++;
        $display("FAIL reen_scan_an t=%0d got=%b want=%b",
                 m_t, an, exp_an()); end
    end
    checks++;
    if (ticks != 0) begin failures++;
      $display("FAIL reen_no_tick got=%0d want=0", ticks); end
    cyc();
    checks++;
    if (frame_tick !== 1'b1) begin failures++;
      $display("FAIL reen_wrap_tick got=%b want=1",
               frame_tick); end
  endtask

  task automatic test_random();
    logic [15:0] masks [5];
    masks = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0};
    for (int i = 0; i < 1500; i++) begin
      load = ($urandom_range(7) == 0);
      value = 16'($urandom) & masks[$urandom_range(4)];
      dp_mask = 4'($urandom);
      if ($urandom_range(15) == 0) blank_lz = ~blank_lz;
      if (enable) enable = ($urandom_range(99) != 0);
      else        enable = ($urandom_range(3) == 0);
      cyc();
      checks += 3;
      if (an !== exp_an()) begin failures++;
        $display("FAIL rnd_an i=%0d got=%b want=%b",
                 i, an, exp_an()); end
      if (seg !== exp_seg()) begin failures++;
        $display("FAIL rnd_seg i=%0d got=%h want=%h",
                 i, seg, exp_seg()); end
      if (frame_tick !== m_tick) begin failures++;
        $display("FAIL rnd_tick i=%0d got=%b want=%b",
                 i, frame_tick, m_tick); end
    end
    load = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_scan();
    test_lz();
    test_dp();
    test_load_timing();
    test_enable_drop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
